// File: rtl/dmem_pkg.sv
// dmem_pkg: shared states, default parameters and error-cause encoding for the data-memory responder.
package dmem_pkg;
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;
    typedef enum logic [1:0] {ERR_NONE, ERR_ALIGN, ERR_RANGE, ERR_OPS} err_e;
    localparam int DEF_WAIT_CYCLES = 2;
    localparam int DEF_ADDR_BITS = 9;
    // Simultaneous load+store outranks address faults; misalignment outranks range.
    function automatic err_e err_cause(input logic [31:0] addr, input logic rd, input logic wr, input int abits);
        return (rd && wr) ? ERR_OPS : (addr[1:0] != 2'b00) ? ERR_ALIGN : ((addr >> abits) != '0) ? ERR_RANGE : ERR_NONE;
    endfunction
endpackage

// File: rtl/dmem_array.sv
// dmem_array: word-wide storage with synchronous write and combinational read; never cleared.
module dmem_array #(
    parameter int AW = 7
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] addr_i,
    input  logic [31:0]   wdata_i,
    output logic [31:0]   rdata_o
);
    logic [31:0] mem_q [2**AW];
    always_ff @(posedge clk)
        if (we_i) mem_q[addr_i] <= wdata_i;
    assign rdata_o = mem_q[addr_i];
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: wait-state data-memory slave; captures one access, waits WAIT_CYCLES, then strobes MemReady.
module dmem_responder import dmem_pkg::*; #(
    parameter int WAIT_CYCLES = DEF_WAIT_CYCLES,
    parameter int ADDR_BITS   = DEF_ADDR_BITS
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [31:0] dAddress,
    input  logic [31:0] dWriteData,
    output logic [31:0] dReadData,
    output logic        MemReady,
    output logic        MemErr
);
    localparam int AW = ADDR_BITS - 2;
    state_e        state_q, state_d;
    err_e          err_q, err_d, eff_err;
    logic [3:0]    cnt_q, cnt_d;
    logic [AW-1:0] addr_q, addr_d, eff_addr;
    logic [31:0]   wdata_q, wdata_d, rdata_q, rdata_d, eff_wdata, mem_rdata;
    logic          rd_q, rd_d, wr_q, wr_d, ready_q, ready_d, merr_q, merr_d;
    logic          idle, req, enter_resp, eff_rd, eff_wr, we;

    dmem_array #(.AW(AW)) u_array (
        .clk    (clk),
        .we_i   (we),
        .addr_i (eff_addr),
        .wdata_i(eff_wdata),
        .rdata_o(mem_rdata)
    );

    // In IDLE the live inputs stand in for the captured copy so WAIT_CYCLES=0 completes on the capture edge.
    always_comb begin
        idle       = state_q == S_IDLE;
        req        = MemRead | MemWrite;
        eff_rd     = idle ? MemRead : rd_q;
        eff_wr     = idle ? MemWrite : wr_q;
        eff_err    = idle ? err_cause(dAddress, MemRead, MemWrite, ADDR_BITS) : err_q;
        eff_addr   = idle ? dAddress[ADDR_BITS-1:2] : addr_q;
        eff_wdata  = idle ? dWriteData : wdata_q;
        enter_resp = idle ? req && WAIT_CYCLES == 0 : state_q == S_WAIT && cnt_q == 4'd1;
        we         = enter_resp && eff_wr && eff_err == ERR_NONE;
        state_d    = enter_resp ? S_RESP : (idle && req) ? S_WAIT : (state_q == S_RESP) ? S_IDLE : state_q;
        cnt_d      = (state_q == S_WAIT) ? cnt_q - 4'd1 : cnt_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rd_d       = rd_q;
        wr_d       = wr_q;
        err_d      = err_q;
        ready_d    = enter_resp;
        merr_d     = enter_resp && eff_err != ERR_NONE;
        rdata_d    = (enter_resp && eff_err != ERR_NONE) ? '0 : (enter_resp && eff_rd) ? mem_rdata : rdata_q;
        if (idle && req) begin
            cnt_d   = 4'(WAIT_CYCLES);
            addr_d  = eff_addr;
            wdata_d = dWriteData;
            rd_d    = MemRead;
            wr_d    = MemWrite;
            err_d   = eff_err;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            err_q   <= ERR_NONE;
            rdata_q <= '0;
            ready_q <= 1'b0;
            merr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
            ready_q <= ready_d;
            merr_q  <= merr_d;
        end
    end

    assign dReadData = rdata_q;
    assign MemReady  = ready_q;
    assign MemErr    = merr_q;
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed checks of a WAIT_CYCLES=2 instance and a WAIT_CYCLES=0 instance.
module tb_dmem_responder;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rd2 = 1'b0, wr2 = 1'b0, rd0 = 1'b0, wr0 = 1'b0;
    logic [31:0] a2 = '0, d2 = '0, a0 = '0, d0 = '0;
    logic [31:0] q2, q0;
    logic        rdy2, err2, rdy0, err0;
    int          tests = 0;
    int          fails = 0;

    always #5 clk = ~clk;

    dmem_responder #(.WAIT_CYCLES(2), .ADDR_BITS(9)) dut (
        .clk(clk), .rst(rst), .MemRead(rd2), .MemWrite(wr2), .dAddress(a2), .dWriteData(d2),
        .dReadData(q2), .MemReady(rdy2), .MemErr(err2)
    );

    dmem_responder #(.WAIT_CYCLES(0), .ADDR_BITS(9)) dut0 (
        .clk(clk), .rst(rst), .MemRead(rd0), .MemWrite(wr0), .dAddress(a0), .dWriteData(d0),
        .dReadData(q0), .MemReady(rdy0), .MemErr(err0)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic acc(input bit z, input logic r, input logic w, input logic [31:0] a, input logic [31:0] d,
                       input bit cd, input logic e_err, input logic [31:0] e_data, input string tag);
        int lat = z ? 0 : 2;
        @(negedge clk);
        if (z) begin rd0 = r; wr0 = w; a0 = a; d0 = d; end
        else   begin rd2 = r; wr2 = w; a2 = a; d2 = d; end
        @(posedge clk);
        #1;
        if (z) begin rd0 = 1'b0; wr0 = 1'b0; a0 = 32'hFFFF_FFFF; d0 = '0; end
        else   begin rd2 = 1'b0; wr2 = 1'b0; a2 = 32'hFFFF_FFFF; d2 = '0; end
        for (int i = 0; i < lat; i++) begin
            chk({tag, "_busy"}, 32'(rdy2), 32'd0);
            @(posedge clk);
            #1;
        end
        chk({tag, "_rdy"}, 32'(z ? rdy0 : rdy2), 32'd1);
        chk({tag, "_err"}, 32'(z ? err0 : err2), 32'(e_err));
        if (cd) chk({tag, "_data"}, z ? q0 : q2, e_data);
        @(posedge clk);
        #1;
        chk({tag, "_pulse"}, 32'(z ? rdy0 : rdy2), 32'd0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rdy", 32'(rdy2), 32'd0);
        chk("rst_err", 32'(err2), 32'd0);
        chk("rst_data", q2, 32'd0);
        chk("rst_rdy0", 32'(rdy0), 32'd0);
        chk("rst_data0", q0, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        acc(0, 0, 1, 32'h010, 32'hDEADBEEF, 0, 0, '0, "st010");
        acc(0, 1, 0, 32'h010, '0, 1, 0, 32'hDEADBEEF, "ld010");
        acc(0, 1, 0, 32'h013, '0, 1, 1, 32'h0, "ld_misalign");
        acc(0, 1, 0, 32'h010, '0, 1, 0, 32'hDEADBEEF, "ld010_b");
        acc(0, 1, 0, 32'h200, '0, 1, 1, 32'h0, "ld_range");
        acc(0, 0, 1, 32'h410, 32'h0BAD0BAD, 0, 1, '0, "st_range");
        acc(0, 1, 0, 32'h010, '0, 1, 0, 32'hDEADBEEF, "ld010_c");

        acc(0, 0, 1, 32'h020, 32'h11112222, 0, 0, '0, "st020");
        acc(0, 1, 1, 32'h020, 32'hFFFFFFFF, 1, 1, 32'h0, "both_ops");
        acc(0, 1, 0, 32'h020, '0, 1, 0, 32'h11112222, "ld020");

        acc(0, 0, 1, 32'h030, 32'h000055AA, 0, 0, '0, "st030_old");
        @(negedge clk);
        wr2 = 1'b1; a2 = 32'h030; d2 = 32'hCAFEF00D;
        @(posedge clk);
        #1;
        wr2 = 1'b0; a2 = '0; d2 = '0;
        #1;
        rst = 1'b1;
        #1;
        chk("rst_mid_data", q2, 32'h0);
        chk("rst_mid_rdy", 32'(rdy2), 32'd0);
        chk("rst_mid_err", 32'(err2), 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        acc(0, 1, 0, 32'h030, '0, 1, 0, 32'h000055AA, "ld030");

        acc(1, 0, 1, 32'h004, 32'h12345678, 0, 0, '0, "w0_st004");
        acc(1, 1, 0, 32'h004, '0, 1, 0, 32'h12345678, "w0_ld004");
        acc(1, 1, 0, 32'h005, '0, 1, 1, 32'h0, "w0_misalign");

        acc(0, 0, 1, 32'h008, 32'h0BADF00D, 0, 0, '0, "st008");
        @(negedge clk);
        rd2 = 1'b1; a2 = 32'h008;
        for (int i = 0; i < 13; i++) begin
            @(posedge clk);
            #1;
            if (i == 9) rd2 = 1'b0;
            chk($sformatf("hold_rdy_%0d", i), 32'(rdy2), 32'((i % 4) == 2));
            if ((i % 4) == 2) chk($sformatf("hold_data_%0d", i), q2, 32'h0BADF00D);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter WAIT_CYCLES, default 2, number of wait-state cycles inserted per access (0..15).
REQ-002 Parameter ADDR_BITS, default 9, byte-address width decoded; storage depth is 2**(ADDR_BITS-2) words.
REQ-003 The block SHALL use one clock and an asynchronous, active-high reset, named clk and rst.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst  input  1  asynchronous active-high reset.
REQ-006 MemRead  input  1  load request from the core.
REQ-007 MemWrite  input  1  store request from the core.
REQ-008 dAddress  input  32  byte address of the access.
REQ-009 dWriteData  input  32  store data.
REQ-010 dReadData  output  32  load data, registered.
REQ-011 MemReady  output  1  one-cycle completion strobe; the core stalls while a request is outstanding and MemReady is low.
REQ-012 MemErr  output  1  error flag, valid only while MemReady=1.

Function
REQ-013 FSM states: IDLE, WAIT, RESP; encoding from the shared package.
REQ-014 In IDLE, a clk edge with MemRead|MemWrite high SHALL capture dAddress, dWriteData and the op, and SHALL load the wait counter with WAIT_CYCLES.
REQ-015 IDLE->WAIT when WAIT_CYCLES>0; IDLE->RESP when WAIT_CYCLES=0.
REQ-016 WAIT: counter decrements each edge; on the edge where counter=1, the FSM SHALL move to RESP.
REQ-017 Latency: for a request sampled at edge k, MemReady SHALL be high exactly in the cycle after edge k+WAIT_CYCLES, for one cycle. RESP->IDLE is unconditional.
REQ-018 Inputs are ignored after capture; changes during WAIT/RESP have no effect.
REQ-019 A valid store SHALL update the word at dAddress[ADDR_BITS-1:2] on the edge entering RESP.
REQ-020 A valid load SHALL load dReadData on the edge entering RESP; dReadData otherwise holds its last value.
REQ-021 Error conditions: dAddress[1:0]!=0; any dAddress bit at or above ADDR_BITS set; MemRead and MemWrite both high at capture.
REQ-022 On error: no storage write, dReadData loaded with 0, MemErr=1 with MemReady.
REQ-023 Requests held high past MemReady SHALL be resampled in IDLE on the following edge as a new access; the minimum access spacing is WAIT_CYCLES+2 cycles.
REQ-024 The storage SHALL be word-wide only, with no byte enables.

Reset
REQ-025 On rst high: state=IDLE, counter=0, dReadData=0, MemReady=0, MemErr=0, asynchronously.
REQ-026 Reset mid-access SHALL abort the access; a store not yet in RESP SHALL not be committed.
REQ-027 Storage contents SHALL not be cleared by reset.

Structure
REQ-028 Package dmem_pkg SHALL hold the state enumeration, the default WAIT_CYCLES and ADDR_BITS constants, and the error-cause encoding.
REQ-029 Storage SHALL be a sub-module dmem_array: synchronous write, combinational read, word-indexed; the FSM, counter and checks stay in dmem_responder.

Verification
REQ-030 WAIT_CYCLES=2: store 0xDEADBEEF to 0x010 -> MemReady high in the 3rd cycle after the sampling edge, MemErr=0; then load 0x010 -> dReadData=0xDEADBEEF with MemReady.
REQ-031 WAIT_CYCLES=0: load 0x004 after storing 0x12345678 there -> MemReady in the cycle after the sampling edge, dReadData=0x12345678.
REQ-032 Load 0x013 (misaligned), then load 0x200 (out of range) -> each response has MemReady=1, MemErr=1, dReadData=0; storage is unchanged.
REQ-033 MemRead=MemWrite=1, addr 0x020, data 0xFFFFFFFF -> MemErr=1; a later load of 0x020 returns the prior value.
REQ-034 Store 0xCAFEF00D to 0x030, assert rst during WAIT -> outputs go to 0 immediately; a later load of 0x030 returns the old value, not 0xCAFEF00D.
REQ-035 Hold MemRead high to 0x008 for 10 cycles with WAIT_CYCLES=2 -> MemReady pulses every 4 cycles, each pulse one cycle wide.
